// File: rtl/hazard_stall_controller.sv
// Hazard and stall controller for a simple in-order pipeline.
// It detects load-use hazards, flushes IF/ID after taken jumps, and freezes
// the pipeline while a memory-stage access holds the shared memory port.
// It also counts the cycles in which the PC was held.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_reg1,
  input  logic [2:0]       id_reg2,
  input  logic             id_uses_reg1,
  input  logic             id_uses_reg2,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_dest,
  input  logic             jump_occured,
  input  logic             mem_access_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             fetch_grant,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;

  // A load in EX whose destination is read by the decode instruction.
  assign load_use = ex_mem_read &&
                    ((id_uses_reg1 && (ex_dest == id_reg1)) ||
                     (id_uses_reg2 && (ex_dest == id_reg2)));

  // Next-state and output decode; while reset is held every control output is forced low.
  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    fetch_grant  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      fetch_grant = 1'b0;
    end else begin
      case (state_q)
        RUN, LOAD_STALL: begin
          if ((state_q == RUN) && jump_occured) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES <= 1) begin
              state_d     = RUN;
              flush_cnt_d = 3'd0;
            end else begin
              state_d     = FLUSH;
              flush_cnt_d = 3'(FLUSH_CYCLES - 1);
            end
          end else if (mem_access_req && !mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            fetch_grant = 1'b0;
            pipe_freeze = 1'b1;
            saved_d     = RUN;
            state_d     = MEM_WAIT;
          end else if (mem_access_req && mem_ready) begin
            fetch_grant = 1'b0;
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = RUN;
          end else if ((state_q == RUN) && load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (mem_access_req && !mem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            fetch_grant = 1'b0;
            pipe_freeze = 1'b1;
            saved_d     = FLUSH;
            state_d     = MEM_WAIT;
          end else if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        MEM_WAIT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          fetch_grant = 1'b0;
          pipe_freeze = 1'b1;
          if (mem_ready) begin
            state_d = saved_q;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM state, saved return state and remaining flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;

endmodule
